// File: rtl/data_mem_pkg.sv
// Shared types and constants for the internal data-memory controller.
// DATA_MEM_PARITY_EN widens the stored word by one even-parity bit.
package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [11:0] DEFAULT_BASE_ADDR = 12'h500;
  localparam int unsigned DEPTH             = 1024;
  localparam int unsigned INDEX_W           = 10;

`ifdef DATA_MEM_PARITY_EN
  localparam int unsigned RAM_W = 33;
`else
  localparam int unsigned RAM_W = 32;
`endif

  // Offset of a byte address inside the decoded window; caller truncates.
  function automatic logic [11:0] window_offset(input logic [11:0] addr,
                                                input logic [11:0] base);
    return addr - base;
  endfunction

endpackage

// File: rtl/data_mem_ram.sv
// Single-port synchronous RAM: write on clock, registered read with enable.
// The read register is reset so the controller's load data starts at zero.
module data_mem_ram #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  output logic [WIDTH-1:0]      rdata_o
);

  logic [WIDTH-1:0] mem_q [0:(1<<DEPTH_LOG2)-1];
  logic [WIDTH-1:0] rdata_q;

  // Array contents survive reset; only the read register is cleared.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store controller for the 1024x32 internal RAM with programmable wait states.
// Define DATA_MEM_PARITY_EN to add a stored parity bit and the PErr output.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [11:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned DEPTH_LOG2  = INDEX_W
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        CS,
  input  logic [31:0] Address,
  input  logic        Req,
  input  logic        WR,
  input  logic [31:0] WData,
  output logic [31:0] RData,
  output logic        Ack,
  output logic        Stall,
  output logic        Busy
`ifdef DATA_MEM_PARITY_EN
  ,
  output logic        PErr
`endif
);

  localparam logic [3:0] WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                  wr_q, wr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  busy_q;

  logic [11:0]           addr_off;
  logic                  ram_we, ram_re;
  logic [RAM_W-1:0]      ram_wdata, ram_rdata;
  logic                  unused_addr_bits;

  // Upper address bits are the decoder's business; only the window offset matters.
  assign addr_off         = window_offset(Address[11:0], BASE_ADDR);
  assign unused_addr_bits = ^{Address[31:12], addr_off};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (Req && !CS) begin
          idx_d   = addr_off[DEPTH_LOG2-1:0];
          wr_d    = WR;
          wdata_d = WData;
          cnt_d   = '0;
          state_d = (WAIT_STATES > 0) ? WAIT : ACCESS;
        end
      end
      WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign ram_we = (state_q == ACCESS) && wr_q;
  assign ram_re = (state_q == ACCESS) && !wr_q;

`ifdef DATA_MEM_PARITY_EN
  assign ram_wdata = {^wdata_q, wdata_q};
  // The read register only changes on loads, so this check is naturally sticky.
  assign PErr      = ram_rdata[32] ^ (^ram_rdata[31:0]);
`else
  assign ram_wdata = wdata_q;
`endif

  data_mem_ram #(
    .WIDTH      (RAM_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk_i   (CLK),
    .rst_ni  (RST_n),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (idx_q),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign RData = ram_rdata[31:0];
  assign Ack   = (state_q == DONE);
  assign Stall = (Req & ~CS & ~Ack) | (state_q == WAIT) | (state_q == ACCESS);
  assign Busy  = busy_q;

endmodule
